// File: rtl/buffer_window_reader.sv
// Circular column-buffer read controller: tracks head/tail/fill, issues write and
// read addresses, and streams overlapping PAR_READ-column windows downstream.
// Optional sticky overflow flag: define BUF_READER_OVF_ERR_EN to build it.
module buffer_window_reader #(
    parameter  int ROW_SIZE  = 8,
    parameter  int COLUMNS   = 32,
    parameter  int PAR_WRITE = 4,
    parameter  int PAR_READ  = 4,
    parameter  int STRIDE    = 1,
    localparam int AW        = $clog2(COLUMNS),
    localparam int CW        = $clog2(PAR_WRITE) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_req,
    input  logic [CW-1:0]                wr_cnt,
    output logic                         wr_ready,
    output logic                         buf_wen,
    output logic [PAR_WRITE*AW-1:0]      buf_waddr,
    output logic [PAR_READ*AW-1:0]       buf_raddr,
    input  logic [PAR_READ*ROW_SIZE-1:0] buf_rdata,
    output logic [PAR_READ*ROW_SIZE-1:0] dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [AW:0]                  fill,
    output logic                         err_ovf
);

    localparam int FW = AW + 1;
    localparam logic [FW-1:0] COLS_F     = FW'(COLUMNS);
    localparam logic [FW-1:0] STRIDE_F   = FW'(STRIDE);
    localparam logic [FW-1:0] PAR_READ_F = FW'(PAR_READ);
    localparam logic [AW-1:0] STRIDE_A   = AW'(STRIDE);

    logic [AW-1:0]                  head_q, head_d;
    logic [AW-1:0]                  tail_q, tail_d;
    logic [FW-1:0]                  fill_q, fill_d;
    logic [PAR_READ*ROW_SIZE-1:0]   dout_q, dout_d;
    logic                           dout_valid_q, dout_valid_d;

    logic [FW-1:0]                  free_w;
    logic [FW-1:0]                  wr_cnt_w;
    logic [FW-1:0]                  avail_w;
    logic [AW-1:0]                  next_head_w;
    logic [AW-1:0]                  last_off_w;
    logic                           push_w;
    logic                           pop_w;
    logic                           load_w;

    // Write side: acceptance never looks at the consumer handshake.
    assign free_w     = COLS_F - fill_q;
    assign wr_cnt_w   = FW'(wr_cnt);
    assign wr_ready   = (wr_cnt_w <= free_w);
    assign push_w     = wr_req && wr_ready;
    assign buf_wen    = push_w && (wr_cnt != '0);
    assign last_off_w = (wr_cnt == '0) ? '0 : AW'(wr_cnt - CW'(1));

    // Read side: look one pop ahead so a popped window is refilled the same cycle.
    assign pop_w       = dout_valid_q && dout_ready;
    assign next_head_w = pop_w ? head_q + STRIDE_A : head_q;
    assign avail_w     = pop_w ? fill_q - STRIDE_F : fill_q;
    assign load_w      = (!dout_valid_q || pop_w) && (avail_w >= PAR_READ_F);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        buf_waddr = '0;
        for (int i = 0; i < PAR_WRITE; i++) begin
            buf_waddr[i*AW +: AW] = tail_q + ((CW'(i) < wr_cnt) ? AW'(i) : last_off_w);
        end
    end

    always_comb begin
        buf_raddr = '0;
        for (int j = 0; j < PAR_READ; j++) begin
            buf_raddr[j*AW +: AW] = next_head_w + AW'(j);
        end
    end

    always_comb begin
        head_d       = next_head_w;
        tail_d       = tail_q;
        fill_d       = fill_q + (push_w ? wr_cnt_w : '0) - (pop_w ? STRIDE_F : '0);
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (push_w) begin
            tail_d = tail_q + AW'(wr_cnt);
        end
        if (load_w) begin
            dout_d       = buf_rdata;
            dout_valid_d = 1'b1;
        end else if (pop_w) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            fill_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            fill_q       <= fill_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign fill       = fill_q;

`ifdef BUF_READER_OVF_ERR_EN
    logic err_ovf_q;

    // A request larger than the free space is exactly a request that is not ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
        end else if (wr_req && !wr_ready) begin
            err_ovf_q <= 1'b1;
        end
    end

    assign err_ovf = err_ovf_q;
`else
    assign err_ovf = 1'b0;
`endif

endmodule
